vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Video-memory scheduler for the VGA display path. It shares one single-port synchronous frame-buffer RAM between display refresh fetches and a CPU-side request/acknowledge port. It sits between the VGA timing generator (hBright/vBright) and the RAM, and serialises fetched words into a 1-bit monochrome pixel stream. Display fetches have absolute priority and are never delayed; the CPU is served in every other cycle.

## Interface
- ADDR_W, 16, RAM word-address width
- WORD_W, 16, RAM data width and pixels per word; must be ≥ 8
- WPL, 40, words per active line (640 / 16)
- CLK  in  1  pixel clock; all logic on rising edge
- CLR  in  1  reset, asynchronous, active-low
- hBright  in  1  horizontal active region; toggles every line, including vertical blanking
- vBright  in  1  vertical active region
- cpu_req  in  1  CPU request; held with all fields stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  WORD_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  WORD_W  read data, valid while cpu_ack = 1
- mem_en  out  1  RAM access this cycle
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  WORD_W  RAM write data
- mem_rdata  in  WORD_W  RAM read data, valid the cycle after a read's mem_en
- pix_out  out  1  pixel = shreg[WORD_W-1] & hBright & vBright

## Operation
- Registered state:
  - hB_d: hBright delayed one cycle
  - line_base (ADDR_W)
  - wcol (0..WPL-1)
  - ph (0..WORD_W-1)
  - shreg, nxt (WORD_W)
  - FSM {IDLE, ACK}
- Line-end cycle F: hB_d = 1 and hBright = 0.
  - At F: wcol ← 0 and ph ← 0.
  - If vBright = 1, line_base ← line_base + WPL; otherwise line_base ← 0. Arithmetic is modulo 2^ADDR_W.
- Display slots, which always win the port:
  - S0 (line prefetch) = cycle F+1; reads address line_base.
  - S1 = active cycle (hBright & vBright) with ph = WORD_W-4 and wcol ≠ WPL-1; reads line_base + wcol + 1.
  - No fetch beyond the line end.
- Display read data is captured into nxt in the cycle after the slot.
- While hBright = 0: shreg ← nxt every cycle.
- While hBright & vBright:
  - shreg shifts left by one each cycle, MSB first.
  - ph increments.
  - At ph = WORD_W-1: shreg ← nxt, ph ← 0, wcol ← wcol+1, saturating at WPL-1.
- CPU FSM:
  - IDLE, cpu_req = 1, no display slot: issue this cycle (mem_en = 1, mem_we = cpu_we, mem_addr = cpu_addr, mem_wdata = cpu_wdata), then go to ACK.
  - IDLE with a display slot: the CPU waits and retries the next cycle.
  - ACK: cpu_ack = 1. For reads, cpu_rdata ← mem_rdata, registered at the ACK entry edge +1; for writes, cpu_rdata holds its last value. Go to IDLE. No CPU issue in ACK, so a request held high re-issues the cycle after ack as a new transaction.
- mem_* outputs are combinational from registered state and inputs. When idle, mem_en = mem_we = 0 and mem_addr/mem_wdata hold 0.

## Timing
- Reset (CLR low, async): every register to 0, FSM = IDLE.
  - Outputs: cpu_ack = 0, cpu_rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, pix_out = 0.
  - An in-flight CPU transaction is dropped with no ack; the requester must re-request.
- CPU latency: issue in the request cycle, ack the next cycle.
  - Worst case is one cycle of slot delay: issue at cycle 2, ack at cycle 3.
  - Display slots are never adjacent, so the CPU is never blocked twice in a row.
- Held back-to-back requests: one ack every 2 cycles when no slot collides.
- Display pipeline:
  - A word fetched at ph = WORD_W-4 is in nxt by ph = WORD_W-2.
  - It is loaded at ph = WORD_W-1, so its first pixel appears at the next ph = 0.
  - The first word of a line is fetched at F+1 and is in shreg before hBright rises.
- Simultaneous CPU request and slot: the display read is issued and the CPU request is deferred one cycle. The pixel stream is unaffected.
- Frame wrap: during vertical blanking line_base stays 0, so the first active line reads from address 0.

## Test plan
- Reset: assert CLR low mid-line with cpu_req = 1 → all outputs 0 within the same cycle, no cpu_ack after release, FSM = IDLE.
- Display fetch: RAM[0] = A5F0, RAM[1] = 0FFF.
  - First active line pix_out = 1010010111110000 0000111111111111.
  - mem_en pulses at F+1 with addr 0, then at ph = 12 of word 0 with addr 1.
- Line advance:
  - Line 2 prefetch addr = 40.
  - No mem_en at ph = 12 while wcol = 39.
  - After vBright falls, prefetch addr returns to 0.
- CPU write/read in blanking:
  - Write 0x0123 ← BEEF: mem_we = 1 in the request cycle, ack the next cycle.
  - Read 0x0123: cpu_rdata = BEEF with cpu_ack.
- Collision: cpu_req rises on a ph = 12 cycle → mem_addr = display address that cycle, CPU issue at ph = 13, cpu_ack at ph = 14; pixel stream matches the no-CPU run exactly.
- Held request: cpu_req high for 10 blanking cycles → 5 acks, spaced 2 cycles apart.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// CPU request/acknowledge bus and single-port frame-buffer RAM bus of vga_fb_arbiter.
// The arbiter uses the slave modport; the CPU and RAM side uses the master modport.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [WORD_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port scheduler: display fetches always own the RAM port, the CPU gets
// every other cycle; fetched words are shifted out MSB first as a 1-bit pixel stream.
module vga_fb_arbiter #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int WPL    = 40
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            hBright,
  input  logic            vBright,
  vga_fb_arbiter_if.slave bus,
  output logic            pix_out
);
  localparam int CW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int PW = $clog2(WORD_W);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_ACK    = 1'b1;
  localparam logic [PW-1:0] PH_FETCH = PW'(WORD_W - 4);
  localparam logic [PW-1:0] PH_LAST  = PW'(WORD_W - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WPL - 1);

  logic              r_hb_d;
  logic              r_f_d;
  logic              r_slot_d;
  logic              r_rd;
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CW-1:0]     r_wcol;
  logic [PW-1:0]     r_ph;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] r_nxt;
  logic [WORD_W-1:0] r_rdata;

  logic              w_f;
  logic              w_act;
  logic              w_s1;
  logic              w_slot;
  logic              w_ack;
  logic              w_issue;
  logic [ADDR_W-1:0] w_daddr;

  // F is the first blank cycle of a line; the line prefetch goes out the cycle after.
  assign w_f     = r_hb_d & ~hBright;
  assign w_act   = hBright & vBright;
  assign w_s1    = w_act && (r_ph == PH_FETCH) && (r_wcol != COL_LAST);
  assign w_slot  = r_f_d | w_s1;
  assign w_daddr = r_f_d ? r_base : r_base + ADDR_W'(r_wcol) + ADDR_W'(1);
  assign w_ack   = (r_state == S_ACK);
  // Gated by CLR so a held request cannot reach the RAM while reset is asserted.
  assign w_issue = CLR && !w_ack && bus.cpu_req && !w_slot;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_slot) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = w_daddr;
    end else if (w_issue) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  // Read data is forwarded from the RAM during the ack cycle and held afterwards.
  assign bus.cpu_ack   = w_ack;
  assign bus.cpu_rdata = (w_ack && r_rd) ? bus.mem_rdata : r_rdata;
  assign pix_out       = r_shreg[WORD_W-1] & hBright & vBright;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_hb_d   <= 1'b0;
      r_f_d    <= 1'b0;
      r_slot_d <= 1'b0;
      r_nxt    <= '0;
    end else begin
      r_hb_d   <= hBright;
      r_f_d    <= w_f;
      r_slot_d <= w_slot;
      if (r_slot_d) r_nxt <= bus.mem_rdata;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_base <= '0;
      r_wcol <= '0;
      r_ph   <= '0;
    end else if (w_f) begin
      r_wcol <= '0;
      r_ph   <= '0;
      r_base <= vBright ? r_base + ADDR_W'(WPL) : '0;
    end else if (w_act) begin
      if (r_ph == PH_LAST) begin
        r_ph <= '0;
        if (r_wcol != COL_LAST) r_wcol <= r_wcol + CW'(1);
      end else begin
        r_ph <= r_ph + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_shreg <= '0;
    end else if (!hBright) begin
      r_shreg <= r_nxt;
    end else if (w_act) begin
      r_shreg <= (r_ph == PH_LAST) ? r_nxt : {r_shreg[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= S_IDLE;
      r_rd    <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_issue) begin
          r_state <= S_ACK;
          r_rd    <= ~bus.cpu_we;
        end
        default: begin
          r_state <= S_IDLE;
          if (r_rd) r_rdata <= bus.mem_rdata;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, VGA timing generator, pixel/slot/CPU reference
// model from line/column positions, plus directed reset, table, collision and held-request cases.
module tb_vga_fb_arbiter;
  localparam int WPL  = 40;
  localparam int WW   = 16;
  localparam int HACT = WPL * WW;
  localparam int BLK  = 24;
  localparam int P    = HACT + BLK;
  localparam int NA   = 3;
  localparam int NL   = 5;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  logic hBright = 1'b0;
  logic vBright = 1'b0;
  logic pix_out;

  vga_fb_arbiter_if #(.ADDR_W(16), .WORD_W(16)) bus();

  vga_fb_arbiter #(.ADDR_W(16), .WORD_W(16), .WPL(WPL)) dut (
    .CLK(CLK), .CLR(CLR), .hBright(hBright), .vBright(vBright),
    .bus(bus), .pix_out(pix_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  logic [15:0] ram    [0:65535];
  logic [15:0] shadow [0:65535];
  int ntests = 0;
  int nfail  = 0;
  int x, L;
  bit chk_on = 1'b0;
  bit m_ackdue = 1'b0;
  bit m_ackrd = 1'b0;
  logic [15:0] m_ackdata = '0;
  logic [15:0] m_lastrd = '0;
  logic s_en, s_we, s_ack, s_pix;
  logic [15:0] s_addr, s_wd, s_rd;

  task automatic ce(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h (line %0d x %0d)", nm, act, exp, L, x);
    end
  endtask

  // Reference: slots and pixels follow from the screen position alone.
  task automatic model_check();
    bit act, s0, s1, iss;
    int col;
    logic [15:0] da;
    logic ep;
    col = x / WW;
    act = (x < HACT) && (L < NA);
    s0  = (x == HACT + 1);
    s1  = act && (x % WW == WW - 4) && (col != WPL - 1);
    da  = s0 ? ((L < NA) ? 16'((L + 1) * WPL) : 16'h0) : 16'(L * WPL + col + 1);
    ep  = act ? shadow[16'(L * WPL + col)][4'(WW - 1 - x % WW)] : 1'b0;
    iss = !s0 && !s1 && bus.cpu_req && !m_ackdue;
    ce("pix", 64'(s_pix), 64'(ep));
    ce("ack", 64'(s_ack), 64'(m_ackdue));
    if (m_ackdue) ce("rdata", 64'(s_rd), 64'(m_ackrd ? m_ackdata : m_lastrd));
    if (s0 || s1)
      ce("slot_bus", 64'({s_en, s_we, s_addr}), 64'({1'b1, 1'b0, da}));
    else if (iss)
      ce("cpu_bus", 64'({s_en, s_we, s_addr, s_wd}),
         64'({1'b1, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata}));
    else
      ce("idle_bus", 64'({s_en, s_we, s_addr, s_wd}), 64'(0));
    if (m_ackdue && m_ackrd) m_lastrd = m_ackdata;
    m_ackdue = iss;
    if (iss) begin
      m_ackrd   = !bus.cpu_we;
      m_ackdata = shadow[bus.cpu_addr];
      if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
    end
  endtask

  task automatic adv();
    if (s_en && s_we) ram[s_addr] = s_wd;
    else if (s_en) bus.mem_rdata = ram[s_addr];
    x++;
    if (x == P) begin
      x = 0;
      L = (L + 1) % NL;
    end
    hBright = (x < HACT);
    vBright = (L < NA);
  endtask

  task automatic sample();
    s_en = bus.mem_en; s_we = bus.mem_we; s_addr = bus.mem_addr; s_wd = bus.mem_wdata;
    s_ack = bus.cpu_ack; s_rd = bus.cpu_rdata; s_pix = pix_out;
  endtask

  task automatic cyc();
    @(negedge CLK);
    sample();
    if (chk_on) model_check();
    @(posedge CLK);
    #1;
    adv();
  endtask

  task automatic goto_pos(input int tl, input int tx);
    int n = 0;
    while (!(L == tl && x == tx) && n < NL * P) begin
      cyc();
      n++;
    end
    ce("goto_reached", 64'(L == tl && x == tx), 64'(1));
  endtask

  task automatic rst_outputs(input string nm);
    ce({nm, "_ack"},   64'(bus.cpu_ack),   64'(0));
    ce({nm, "_rdata"}, 64'(bus.cpu_rdata), 64'(0));
    ce({nm, "_en"},    64'(bus.mem_en),    64'(0));
    ce({nm, "_we"},    64'(bus.mem_we),    64'(0));
    ce({nm, "_addr"},  64'(bus.mem_addr),  64'(0));
    ce({nm, "_wdata"}, 64'(bus.mem_wdata), 64'(0));
    ce({nm, "_pix"},   64'(pix_out),       64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int ackpos [$];
    int pend;
    bit got;
    int lat;
    tbl[0] = '{1'b1, 16'h0123, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b0, 16'h0123, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 16'h4567, 16'h1234, 16'h0000};
    tbl[3] = '{1'b0, 16'h4567, 16'h0000, 16'h1234};
    tbl[4] = '{1'b0, 16'h0123, 16'h0000, 16'hBEEF};
    tbl[5] = '{1'b1, 16'h0123, 16'h0F0F, 16'h0000};
    tbl[6] = '{1'b0, 16'h0123, 16'h0000, 16'h0F0F};

    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'($urandom);
      shadow[i] = ram[i];
    end
    ram[0] = 16'hA5F0; shadow[0] = 16'hA5F0;
    ram[1] = 16'h0FFF; shadow[1] = 16'h0FFF;

    x = 280; L = NL - 1;
    hBright = 1'b1; vBright = 1'b0;
    bus.mem_rdata = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0055; bus.cpu_wdata = 16'hFFFF;
    #1;
    rst_outputs("rst_init");
    for (int i = 0; i < 3; i++) cyc();
    bus.cpu_req = 1'b0;
    CLR = 1'b1;
    chk_on = 1'b1;

    // Reset arriving mid-line while a write is waiting for its ack.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h5000; bus.cpu_wdata = 16'h1111;
    cyc();
    #2 CLR = 1'b0;
    #1 rst_outputs("rst_mid");
    bus.cpu_req = 1'b0;
    m_ackdue = 1'b0;
    m_lastrd = '0;
    @(negedge CLK);
    sample();
    @(posedge CLK);
    #1 adv();
    CLR = 1'b1;
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (s_ack) lat++;
    end
    ce("rst_no_ack", 64'(lat), 64'(0));

    // CPU vectors in vertical blanking.
    for (int i = 0; i < 7; i++) begin
      bus.cpu_we = tbl[i].we; bus.cpu_addr = tbl[i].addr; bus.cpu_wdata = tbl[i].wdata;
      bus.cpu_req = 1'b1;
      cyc();
      ce("tbl_issue", 64'({s_en, s_we, s_addr}), 64'({1'b1, tbl[i].we, tbl[i].addr}));
      got = 1'b0;
      lat = 0;
      for (int k = 0; k < 4 && !got; k++) begin
        cyc();
        lat++;
        if (s_ack) got = 1'b1;
      end
      ce("tbl_ack_seen", 64'(got), 64'(1));
      ce("tbl_ack_latency", 64'(lat), 64'(1));
      if (!tbl[i].we) ce("tbl_rdata", 64'(s_rd), 64'(tbl[i].exp_rd));
      bus.cpu_req = 1'b0;
    end

    // Request held for 10 blanking cycles.
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h4567; bus.cpu_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (s_ack) ackpos.push_back(k);
    end
    bus.cpu_req = 1'b0;
    ce("held_acks", 64'(ackpos.size()), 64'(5));
    for (int k = 0; k < ackpos.size(); k++) ce("held_pos", 64'(ackpos[k]), 64'(2 * k + 1));

    // Request rising on the ph=12 fetch cycle of word 5 of the first active line.
    goto_pos(0, 5 * WW + 12);
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h4567; bus.cpu_req = 1'b1;
    cyc();
    ce("col_slot", 64'({s_en, s_we, s_addr, s_ack}), 64'({1'b1, 1'b0, 16'd6, 1'b0}));
    cyc();
    ce("col_issue", 64'({s_en, s_we, s_addr, s_ack}), 64'({1'b1, 1'b0, 16'h4567, 1'b0}));
    cyc();
    ce("col_ack", 64'({s_ack, s_rd}), 64'({1'b1, 16'h1234}));
    bus.cpu_req = 1'b0;

    // Random CPU traffic across the rest of the frames.
    pend = 0;
    for (int i = 0; i < 5500; i++) begin
      if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = 16'h4000 + 16'($urandom_range(0, 31));
        bus.cpu_wdata = 16'($urandom);
        bus.cpu_req   = 1'b1;
        pend = 0;
      end
      cyc();
      if (bus.cpu_req) begin
        if (s_ack) bus.cpu_req = 1'b0;
        else begin
          pend++;
          if (pend > 3) begin
            ce("cpu_ack_wait", 64'(pend), 64'(3));
            bus.cpu_req = 1'b0;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
